aes_gcm_output_stage: RTL

AES_GCM_OUTPUT_STAGE -- requirements
Module: aes_gcm_output_stage

---
 rtl/aes_gcm_pkg.sv | 18 +
 rtl/aes_gcm_output_stage_if.sv | 14 +
 rtl/aes_sync_fifo.sv | 49 ++++
 rtl/aes_gcm_output_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/aes_gcm_pkg.sv
// Shared types for the AES-GCM output stage: FIFO entry layout and tracker states.
package aes_gcm_pkg;

  localparam int BLOCK_BITS = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AAD  = 2'd1,
    ST_TEXT = 2'd2
  } gcm_state_e;

  typedef struct packed {
    logic                  is_tag;
    logic                  auth_fail;
    logic [0:BLOCK_BITS-1] data;
  } out_entry_t;

endpackage

// File: rtl/aes_gcm_output_stage_if.sv
// Output beat stream of the AES-GCM output stage (ciphertext or tag beats).
interface aes_gcm_output_stage_if;
  import aes_gcm_pkg::*;

  logic [0:BLOCK_BITS-1] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_is_tag;
  logic                  o_auth_fail;

  modport master (output o_data, o_valid, o_is_tag, o_auth_fail, input i_ready);
  modport slave  (input o_data, o_valid, o_is_tag, o_auth_fail, output i_ready);

endinterface

// File: rtl/aes_sync_fifo.sv
// Single-clock FIFO; head entry comes straight from the storage registers and reads 0 when empty.
module aes_sync_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_gcm_output_stage.sv
// AES-GCM output stage: filters AAD blocks, queues ciphertext and tag beats, flags protocol errors.
// state   | meaning
// IDLE    | no instance open; only a new-instance block is legal
// AAD     | next block index is below the AAD block count (dropped)
// TEXT    | next block index is in the text range (queued) or at the tag
module aes_gcm_output_stage
  import aes_gcm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic                  i_new_instance,
  input  logic [0:BLOCK_BITS-1] i_instance_size,
  input  logic [0:BLOCK_BITS-1] i_cipher_text,
  input  logic                  i_tag_ready,
  input  logic [0:BLOCK_BITS-1] i_tag,
  input  logic                  i_decrypt,
  input  logic [0:BLOCK_BITS-1] i_expected_tag,
  aes_gcm_output_stage_if.master ostream,
  output logic                  o_overflow,
  output logic                  o_proto_err
);
  gcm_state_e  state_q, state_d;
  logic [63:0] k_q, k_d, aad_q, aad_d, tot_q, tot_d, cur_k;
  logic        dec_q, dec_d, perr_d;
  logic [64:0] size_sum;
  logic        push, pop, fifo_full, fifo_empty;
  out_entry_t  push_entry, head;

  assign size_sum = {1'b0, i_instance_size[0:63]} + {1'b0, i_instance_size[64:127]};
  assign pop      = !fifo_empty && ostream.i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      aad_q       <= '0;
      tot_q       <= '0;
      dec_q       <= 1'b0;
      o_proto_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      aad_q       <= aad_d;
      tot_q       <= tot_d;
      dec_q       <= dec_d;
      o_proto_err <= perr_d;
      if (push && fifo_full && !pop) o_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    aad_d      = aad_q;
    tot_d      = tot_q;
    dec_d      = dec_q;
    perr_d     = o_proto_err;
    push       = 1'b0;
    push_entry = '0;
    cur_k      = i_new_instance ? '0 : k_q;
    if (i_valid) begin
      if (i_new_instance) begin
        if (state_q != ST_IDLE) perr_d = 1'b1;
        aad_d = i_instance_size[0:63] >> 7;
        tot_d = 64'(size_sum >> 7);
        dec_d = i_decrypt;
      end
      if (!i_new_instance && state_q == ST_IDLE) begin
        perr_d = 1'b1;
      end else if (i_tag_ready) begin
        if (cur_k != tot_d) perr_d = 1'b1;
        push                 = 1'b1;
        push_entry.is_tag    = 1'b1;
        push_entry.auth_fail = dec_d && (i_tag != i_expected_tag);
        push_entry.data      = i_tag;
        state_d              = ST_IDLE;
        k_d                  = '0;
      end else begin
        push            = (cur_k >= aad_d) && (cur_k < tot_d);
        push_entry.data = i_cipher_text;
        k_d             = cur_k + 64'd1;
        state_d         = (k_d < aad_d) ? ST_AAD : ST_TEXT;
      end
    end
  end

  aes_sync_fifo #(
    .WIDTH($bits(out_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (push_entry),
    .pop  (pop),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign ostream.o_valid     = !fifo_empty;
  assign ostream.o_data      = head.data;
  assign ostream.o_is_tag    = head.is_tag;
  assign ostream.o_auth_fail = head.auth_fail;

endmodule
